// File: rtl/mac_result_accumulator.sv
// -----------------------------------------------------------------------------
// mac_result_accumulator
//
// Purpose:
//   Downstream stage of the MAC ALU. Each 2*NBITS-bit result the ALU produces
//   is added into a wider saturating accumulator. After BURST_LEN accepted
//   samples the total is presented on a valid/ready output and held until the
//   consumer takes it. The block lives in the always-on domain, so a partial
//   sum survives the ALU going to sleep or losing supply.
//
// Parameters:
//   NBITS      ALU operand width; in_data is 2*NBITS bits wide
//   ACC_W      accumulator / out_data width, at least 2*NBITS+1
//   BURST_LEN  accepted samples per accumulated result, at least 1
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   alu_active  in   1 = upstream ALU powered and awake
//   in_valid    in   in_data holds a valid ALU result
//   in_data     in   ALU result, unsigned
//   in_ready    out  sample can be taken this cycle (combinational)
//   acc_clear   in   synchronous clear of sum, count, flags and pending result
//   out_valid   out  out_data holds a completed burst sum
//   out_data    out  burst sum
//   out_ready   in   consumer takes out_data
//   out_sat     out  current / presented burst saturated
//   count       out  samples accepted in the current burst
//   iso_err     out  (only with MAC_ACC_ISO_CHECK_EN) sticky flag: in_valid
//                    was seen while alu_active was low
//
// Build option:
//   MAC_ACC_ISO_CHECK_EN  when defined, adds the iso_err port and its logic.
// -----------------------------------------------------------------------------
module mac_result_accumulator #(
    parameter int NBITS     = 8,
    parameter int ACC_W     = 24,
    parameter int BURST_LEN = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alu_active,
    input  logic                             in_valid,
    input  logic [2*NBITS-1:0]               in_data,
    output logic                             in_ready,
    input  logic                             acc_clear,
    output logic                             out_valid,
    output logic [ACC_W-1:0]                 out_data,
    input  logic                             out_ready,
    output logic                             out_sat,
    output logic [$clog2(BURST_LEN+1)-1:0]   count
`ifdef MAC_ACC_ISO_CHECK_EN
    ,
    output logic                             iso_err
`endif
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    // Count value that closes a burst.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN);

    // Zero bits needed to widen in_data to the carry-extended sum width.
    localparam int PAD_W = ACC_W + 1 - 2 * NBITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;  // awake, no samples yet
    localparam logic [1:0] ST_ACCUM = 2'd1;  // awake, burst in progress
    localparam logic [1:0] ST_HOLD  = 2'd2;  // result presented, waiting for consumer
    localparam logic [1:0] ST_SLEEP = 2'd3;  // ALU asleep, partial sum parked

    logic [1:0]       state_q,     state_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q,  out_data_d;
    logic             out_sat_q,   out_sat_d;

    logic             in_ready_w;
    logic             accept_w;
    logic [ACC_W:0]   sum_wide_w;
    logic             sum_ovf_w;
    logic [ACC_W-1:0] sum_clamped_w;
    logic [CNT_W-1:0] cnt_inc_w;
    logic             burst_done_w;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // A sample is only taken while the ALU is awake, no result is waiting and
    // no clear is requested. In SLEEP in_ready stays low during the wake cycle
    // itself, so the first sample after a wake lands one cycle later.
    assign in_ready_w = alu_active
                      & ((state_q == ST_IDLE) | (state_q == ST_ACCUM))
                      & ~acc_clear;
    assign accept_w   = in_valid & in_ready_w;

    // -------------------------------------------------------------------------
    // Saturating add
    // -------------------------------------------------------------------------
    // One extra bit catches the carry; any carry means the true sum exceeded
    // the all-ones value and the result pins there.
    assign sum_wide_w    = {1'b0, acc_q} + {{PAD_W{1'b0}}, in_data};
    assign sum_ovf_w     = sum_wide_w[ACC_W];
    assign sum_clamped_w = sum_ovf_w ? {ACC_W{1'b1}} : sum_wide_w[ACC_W-1:0];

    // cnt_q never exceeds BURST_LEN-1 when an accept is possible, so the
    // increment cannot wrap.
    assign cnt_inc_w    = cnt_q + 1'b1;
    assign burst_done_w = (cnt_inc_w == CNT_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (acc_clear) begin
            // Clear wins over everything, including a pending result.
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_sat_d   = 1'b0;
            state_d     = alu_active ? ST_IDLE : ST_SLEEP;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (!alu_active) begin
                        // Park the partial sum; nothing is accepted this cycle
                        // because in_ready is already low.
                        state_d = ST_SLEEP;
                    end else if (accept_w) begin
                        acc_d = sum_clamped_w;
                        cnt_d = cnt_inc_w;
                        if (sum_ovf_w) begin
                            out_sat_d = 1'b1;
                        end
                        if (burst_done_w) begin
                            state_d     = ST_HOLD;
                            out_valid_d = 1'b1;
                            out_data_d  = sum_clamped_w;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end
                end

                ST_HOLD: begin
                    // alu_active is deliberately ignored here: the consumer can
                    // drain the result while the ALU sleeps.
                    if (out_ready) begin
                        acc_d       = '0;
                        cnt_d       = '0;
                        out_sat_d   = 1'b0;
                        out_valid_d = 1'b0;
                        state_d     = alu_active ? ST_IDLE : ST_SLEEP;
                    end
                end

                ST_SLEEP: begin
                    if (alu_active) begin
                        state_d = (cnt_q == '0) ? ST_IDLE : ST_ACCUM;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    // -------------------------------------------------------------------------
    // Optional isolation monitor
    // -------------------------------------------------------------------------
`ifdef MAC_ACC_ISO_CHECK_EN
    logic iso_err_q, iso_err_d;

    // A valid strobe from a powered-down ALU points at broken isolation.
    // The sample itself is dropped by the handshake logic above.
    always_comb begin
        iso_err_d = iso_err_q;
        if (acc_clear) begin
            iso_err_d = 1'b0;
        end else if (in_valid && !alu_active) begin
            iso_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iso_err_q <= 1'b0;
        end else begin
            iso_err_q <= iso_err_d;
        end
    end

    assign iso_err = iso_err_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = in_ready_w;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign count     = cnt_q;

endmodule

// File: tb/tb_mac_result_accumulator.sv
// -----------------------------------------------------------------------------
// Bench for mac_result_accumulator. Three instances share one stimulus stream:
//   u0: default build (ACC_W=24, BURST_LEN=4)
//   u1: narrow accumulator (ACC_W=17) so saturation happens often
//   u2: BURST_LEN=1
// A transaction-level model predicts every output each cycle; directed
// scenarios add literal expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_mac_result_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        act;
    logic        iv;
    logic [15:0] id;
    logic        clr;
    logic        ordy;

    logic        rdy0, ov0, os0;
    logic [23:0] od0;
    logic [2:0]  cnt0;
    logic        rdy1, ov1, os1;
    logic [16:0] od1;
    logic [2:0]  cnt1;
    logic        rdy2, ov2, os2;
    logic [23:0] od2;
    logic [0:0]  cnt2;
`ifdef MAC_ACC_ISO_CHECK_EN
    logic        iso0, iso1, iso2;
`endif

    always #5 clk = ~clk;

    mac_result_accumulator #(.NBITS(8), .ACC_W(24), .BURST_LEN(4)) u0 (
        .clk(clk), .rst(rst), .alu_active(act), .in_valid(iv), .in_data(id),
        .in_ready(rdy0), .acc_clear(clr), .out_valid(ov0), .out_data(od0),
        .out_ready(ordy), .out_sat(os0), .count(cnt0)
`ifdef MAC_ACC_ISO_CHECK_EN
        , .iso_err(iso0)
`endif
    );

    mac_result_accumulator #(.NBITS(8), .ACC_W(17), .BURST_LEN(4)) u1 (
        .clk(clk), .rst(rst), .alu_active(act), .in_valid(iv), .in_data(id),
        .in_ready(rdy1), .acc_clear(clr), .out_valid(ov1), .out_data(od1),
        .out_ready(ordy), .out_sat(os1), .count(cnt1)
`ifdef MAC_ACC_ISO_CHECK_EN
        , .iso_err(iso1)
`endif
    );

    mac_result_accumulator #(.NBITS(8), .ACC_W(24), .BURST_LEN(1)) u2 (
        .clk(clk), .rst(rst), .alu_active(act), .in_valid(iv), .in_data(id),
        .in_ready(rdy2), .acc_clear(clr), .out_valid(ov2), .out_data(od2),
        .out_ready(ordy), .out_sat(os2), .count(cnt2)
`ifdef MAC_ACC_ISO_CHECK_EN
        , .iso_err(iso2)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;
    int txn      = 0;

    // Reference model: one entry per instance.
    longint m_acc[3];
    longint m_pd[3];
    longint maxv[3];
    int     m_cnt[3];
    int     bl[3];
    bit     m_sat[3];
    bit     m_pv[3];
    bit     prev_act;   // the block reacts to alu_active one cycle late
    bit     m_iso;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0;
            m_pd[k]  = 0;
            m_cnt[k] = 0;
            m_sat[k] = 1'b0;
            m_pv[k]  = 1'b0;
        end
        prev_act = 1'b1;
        m_iso    = 1'b0;
    endtask

    // Apply one clock edge worth of the rules to the model.
    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            bit     can_take;
            longint s;
            can_take = act && prev_act && !clr && !m_pv[k];
            if (clr) begin
                m_acc[k] = 0;
                m_pd[k]  = 0;
                m_cnt[k] = 0;
                m_sat[k] = 1'b0;
                m_pv[k]  = 1'b0;
            end else if (m_pv[k]) begin
                if (ordy) begin
                    if (k == 0) begin
                        txn++;
                        $display("txn %0d: burst sum %0d sat %0b", txn, m_pd[0], m_sat[0]);
                    end
                    m_pv[k]  = 1'b0;
                    m_acc[k] = 0;
                    m_cnt[k] = 0;
                    m_sat[k] = 1'b0;
                end
            end else if (iv && can_take) begin
                s = m_acc[k] + longint'(id);
                if (s > maxv[k]) begin
                    s        = maxv[k];
                    m_sat[k] = 1'b1;
                end
                m_acc[k] = s;
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == bl[k]) begin
                    m_pv[k] = 1'b1;
                    m_pd[k] = s;
                end
            end
        end
        if (clr) m_iso = 1'b0;
        else if (iv && !act) m_iso = 1'b1;
        prev_act = act;
    endtask

    task automatic chk_inst(input int k, input logic r, input logic v, input longint d,
                            input logic s, input longint c);
        chk($sformatf("u%0d.in_ready", k), longint'(r),
            longint'(act && prev_act && !clr && !m_pv[k]));
        chk($sformatf("u%0d.out_valid", k), longint'(v), longint'(m_pv[k]));
        chk($sformatf("u%0d.out_data", k), d, m_pd[k]);
        chk($sformatf("u%0d.out_sat", k), longint'(s), longint'(m_sat[k]));
        chk($sformatf("u%0d.count", k), c, longint'(m_cnt[k]));
    endtask

    task automatic check_all();
        chk_inst(0, rdy0, ov0, longint'(od0), os0, longint'(cnt0));
        chk_inst(1, rdy1, ov1, longint'(od1), os1, longint'(cnt1));
        chk_inst(2, rdy2, ov2, longint'(od2), os2, longint'(cnt2));
`ifdef MAC_ACC_ISO_CHECK_EN
        chk("u0.iso_err", longint'(iso0), longint'(m_iso));
        chk("u1.iso_err", longint'(iso1), longint'(m_iso));
        chk("u2.iso_err", longint'(iso2), longint'(m_iso));
`endif
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input bit a, input bit v, input logic [15:0] d,
                        input bit c, input bit r);
        act  = a;
        iv   = v;
        id   = d;
        clr  = c;
        ordy = r;
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        act  = 1'b1;
        iv   = 1'b0;
        id   = '0;
        clr  = 1'b0;
        ordy = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit          a_state;
        logic [15:0] rnd_d;

        maxv[0] = (64'd1 << 24) - 1;  bl[0] = 4;
        maxv[1] = (64'd1 << 17) - 1;  bl[1] = 4;
        maxv[2] = (64'd1 << 24) - 1;  bl[2] = 1;
        rst  = 1'b1;
        act  = 1'b1;
        iv   = 1'b0;
        id   = '0;
        clr  = 1'b0;
        ordy = 1'b0;
        model_reset();
        @(negedge clk);

        // 1: reset in the middle of a burst
        do_reset();
        step(1, 1, 16'd10, 0, 1);
        step(1, 1, 16'd20, 0, 1);
        do_reset();
        chk("t1 out_valid", longint'(ov0), 0);
        chk("t1 out_data", longint'(od0), 0);
        chk("t1 out_sat", longint'(os0), 0);
        chk("t1 count", longint'(cnt0), 0);
        act = 1'b1; iv = 1'b0; clr = 1'b0;
        #1;
        chk("t1 in_ready", longint'(rdy0), 1);

        // 2: back-to-back burst, one-cycle output pulse
        step(1, 1, 16'd10, 0, 1);
        step(1, 1, 16'd20, 0, 1);
        step(1, 1, 16'd30, 0, 1);
        step(1, 1, 16'd40, 0, 1);
        chk("t2 out_valid", longint'(ov0), 1);
        chk("t2 out_data", longint'(od0), 100);
        step(1, 0, 16'd0, 0, 1);
        chk("t2 out_valid low", longint'(ov0), 0);
        chk("t2 count", longint'(cnt0), 0);

        // 3: back-pressure holds the result and blocks new samples
        do_reset();
        step(1, 1, 16'd1, 0, 0);
        step(1, 1, 16'd2, 0, 0);
        step(1, 1, 16'd3, 0, 0);
        step(1, 1, 16'd4, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 16'd9, 0, 0);
        chk("t3 out_data", longint'(od0), 10);
        chk("t3 out_valid", longint'(ov0), 1);
        step(1, 1, 16'd9, 0, 1);
        step(1, 1, 16'd9, 0, 0);
        chk("t3 count", longint'(cnt0), 1);

        // 4: saturation on the narrow instance, then a clean burst
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 16'hFFFF, 0, 0);
        chk("t4 sat data", longint'(od1), 64'h1FFFF);
        chk("t4 sat flag", longint'(os1), 1);
        chk("t4 wide data", longint'(od0), 64'h3FFFC);
        step(1, 0, 16'd0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 16'd1, 0, 0);
        chk("t4 clean data", longint'(od1), 4);
        chk("t4 clean sat", longint'(os1), 0);
        step(1, 0, 16'd0, 0, 1);

        // 5: partial sum survives sleep; wake cycle offers a sample that is dropped
        do_reset();
        step(1, 1, 16'd5, 0, 1);
        step(1, 1, 16'd6, 0, 1);
        for (int i = 0; i < 50; i++) step(0, 1, 16'd99, 0, 1);
        step(1, 1, 16'd7, 0, 1);
        step(1, 1, 16'd7, 0, 1);
        step(1, 1, 16'd8, 0, 0);
        chk("t5 out_valid", longint'(ov0), 1);
        chk("t5 out_data", longint'(od0), 26);
`ifdef MAC_ACC_ISO_CHECK_EN
        chk("t5 iso_err", longint'(iso0), 1);
`endif
        step(1, 0, 16'd0, 0, 1);

        // 6: clear in the cycle of the third sample
        do_reset();
        step(1, 1, 16'd3, 0, 0);
        step(1, 1, 16'd3, 0, 0);
        step(1, 1, 16'd3, 1, 0);
        chk("t6 count", longint'(cnt0), 0);
        for (int i = 0; i < 4; i++) step(1, 1, 16'd1, 0, 0);
        chk("t6 out_data", longint'(od0), 4);
        step(1, 0, 16'd0, 0, 1);

        // Randomized phase
        do_reset();
        a_state = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end
            if ($urandom_range(0, 99) < 4) a_state = !a_state;
            rnd_d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            step(a_state,
                 ($urandom_range(0, 99) < 70),
                 rnd_d,
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 60));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
